// File: rtl/myfiraxi_axil_slave_if.sv
// AXI4-Lite bus bundle for the myfiraxi register block.
// Ports (all named as on the AXI VIP master agent):
//   write address : S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_AWREADY
//   write data    : S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WREADY
//   write resp    : S_AXI_BRESP, S_AXI_BVALID, S_AXI_BREADY
//   read address  : S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_ARREADY
//   read data     : S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, S_AXI_RREADY
// Modports: master (interconnect / VIP side), slave (register block side).
interface myfiraxi_axil_slave_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/myfiraxi_axil_slave.sv
// AXI4-Lite responder holding the four 32-bit registers of the myfiraxi FIR
// peripheral (byte offsets 0x0, 0x4, 0x8, 0xC; index = addr[3:2]).
// Ports:
//   S_AXI_ACLK    - clock, rising edge
//   S_AXI_ARESETN - asynchronous active-low reset
//   s_axi         - AXI4-Lite slave bundle (myfiraxi_axil_slave_if.slave)
//   reg_q         - register contents, reg n at [32n+31:32n]
//   reg_wr_pulse  - one-hot, one-cycle commit strobe per register write
// Build option: define MYFIRAXI_WSTRB_EN to honour WSTRB byte lanes;
// otherwise every write replaces the full 32-bit word.
module myfiraxi_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  myfiraxi_axil_slave_if.slave            s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [3:0]                      reg_wr_pulse
);

  typedef enum logic [1:0] {W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs;
  logic [1:0]                         aw_idx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]      w_data_q;
  logic [3:0]                         w_strb_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]      rdata_q;

  // Holds every READY low through reset and for the first edge after it.
  logic ready_en;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic commit;
  logic [1:0]                    commit_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;
  logic [3:0]                    commit_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_word;

  assign aw_hs = s_axi.S_AXI_AWVALID && aw_ready;
  assign w_hs  = s_axi.S_AXI_WVALID  && w_ready;
  assign b_hs  = b_valid && s_axi.S_AXI_BREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID && ar_ready;
  assign r_hs  = r_valid && s_axi.S_AXI_RREADY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else                w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_nxt = W_RESP;
        else if (aw_hs)    w_state_nxt = W_GOT_ADDR;
        else if (w_hs)     w_state_nxt = W_GOT_DATA;
      end
      W_GOT_ADDR: if (w_hs)  w_state_nxt = W_RESP;
      W_GOT_DATA: if (aw_hs) w_state_nxt = W_RESP;
      W_RESP:     if (b_hs)  w_state_nxt = W_IDLE;
      default:    w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = ready_en && ((w_state == W_IDLE) || (w_state == W_GOT_DATA));
    w_ready  = ready_en && ((w_state == W_IDLE) || (w_state == W_GOT_ADDR));
    b_valid  = (w_state == W_RESP);
  end

  // Commit on the edge that enters W_RESP; the beat arriving on that edge
  // has not been latched yet, so take it straight from the bus.
  assign commit      = (w_state != W_RESP) && (w_state_nxt == W_RESP);
  assign commit_idx  = aw_hs ? s_axi.S_AXI_AWADDR[3:2] : aw_idx_q;
  assign commit_data = w_hs  ? s_axi.S_AXI_WDATA       : w_data_q;
  assign commit_strb = w_hs  ? s_axi.S_AXI_WSTRB       : w_strb_q;

`ifdef MYFIRAXI_WSTRB_EN
  always_comb begin
    wr_word = regs[commit_idx];
    for (int unsigned k = 0; k < 4; k++) begin
      if (commit_strb[k]) wr_word[8*k +: 8] = commit_data[8*k +: 8];
    end
  end
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
`else
  always_comb begin
    wr_word = commit_data;
  end
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                         commit_strb};
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      regs         <= '0;
      reg_wr_pulse <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= s_axi.S_AXI_AWADDR[3:2];
      if (w_hs) begin
        w_data_q <= s_axi.S_AXI_WDATA;
        w_strb_q <= s_axi.S_AXI_WSTRB;
      end
      reg_wr_pulse <= '0;
      if (commit) begin
        regs[commit_idx]         <= wr_word;
        reg_wr_pulse[commit_idx] <= 1'b1;
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= R_IDLE;
    else                r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs)  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = ready_en && (r_state == R_IDLE);
    r_valid  = (r_state == R_DATA);
  end

  // Samples regs before any same-edge commit lands, so a colliding read
  // returns the old value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)  rdata_q <= '0;
    else if (ar_hs)      rdata_q <= regs[s_axi.S_AXI_ARADDR[3:2]];
  end

  // ---------------- outputs ----------------
  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = b_valid;
  assign s_axi.S_AXI_BRESP   = '0;
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RVALID  = r_valid;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = '0;
  assign reg_q               = regs;

endmodule

// File: tb/tb_myfiraxi_axil_slave.sv
// Self-checking bench for myfiraxi_axil_slave: a transaction-level model of
// the register file and outstanding-beat bookkeeping is compared against the
// DUT every cycle, alongside directed scenarios with literal expectations.
module tb_myfiraxi_axil_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  myfiraxi_axil_slave_if bus ();
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  myfiraxi_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake at %0t", name, $time);
  endtask

  // ---------------- model ----------------
  // A write is "pending" per channel until both beats are in; while a
  // response is owed no new beat may be taken. Reads are one at a time.
  logic        m_init, m_have_aw, m_have_w, m_b, m_r;
  logic [1:0]  m_aw_idx;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic [31:0] m_regs [4];
  logic [3:0]  m_pulse;
  logic [31:0] m_rdata;
  logic        m_awr, m_wr, m_arr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init = 0; m_have_aw = 0; m_have_w = 0; m_b = 0; m_r = 0;
      m_aw_idx = 0; m_w_data = 0; m_w_strb = 0; m_pulse = 0; m_rdata = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
    end else begin
      m_awr = m_init && !m_have_aw && !m_b;
      m_wr  = m_init && !m_have_w && !m_b;
      m_arr = m_init && !m_r;
      m_pulse = 0;
      if (m_r && bus.S_AXI_RREADY) m_r = 0;
      if (m_arr && bus.S_AXI_ARVALID) begin
        m_rdata = m_regs[bus.S_AXI_ARADDR / 4];
        m_r = 1;
      end
      if (m_b && bus.S_AXI_BREADY) m_b = 0;
      if (m_awr && bus.S_AXI_AWVALID) begin
        m_have_aw = 1;
        m_aw_idx = bus.S_AXI_AWADDR / 4;
      end
      if (m_wr && bus.S_AXI_WVALID) begin
        m_have_w = 1;
        m_w_data = bus.S_AXI_WDATA;
        m_w_strb = bus.S_AXI_WSTRB;
      end
      if (m_have_aw && m_have_w) begin
`ifdef MYFIRAXI_WSTRB_EN
        for (int k = 0; k < 4; k++)
          if (m_w_strb[k]) m_regs[m_aw_idx][8*k +: 8] = m_w_data[8*k +: 8];
`else
        m_regs[m_aw_idx] = m_w_data;
`endif
        m_pulse = 4'b0001 << m_aw_idx;
        m_b = 1;
        m_have_aw = 0;
        m_have_w = 0;
      end
      m_init = 1;
    end
  end

  always @(negedge clk) begin
    check("awready", bus.S_AXI_AWREADY, m_init && !m_have_aw && !m_b);
    check("wready",  bus.S_AXI_WREADY,  m_init && !m_have_w && !m_b);
    check("bvalid",  bus.S_AXI_BVALID,  m_b);
    check("bresp",   bus.S_AXI_BRESP,   2'b00);
    check("arready", bus.S_AXI_ARREADY, m_init && !m_r);
    check("rvalid",  bus.S_AXI_RVALID,  m_r);
    check("rresp",   bus.S_AXI_RRESP,   2'b00);
    if (m_r) check("rdata", bus.S_AXI_RDATA, m_rdata);
    check("reg_q", reg_q, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    check("reg_wr_pulse", reg_wr_pulse, m_pulse);
  end

  // ---------------- bus tasks (called at posedge+#1) ----------------
  task automatic send_aw(input logic [3:0] a);
    bus.S_AXI_AWADDR = a;
    bus.S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY) begin
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        return;
      end
    end
    bus.S_AXI_AWVALID = 1'b0;
    timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bus.S_AXI_WDATA = d;
    bus.S_AXI_WSTRB = s;
    bus.S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.S_AXI_WREADY) begin
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        return;
      end
    end
    bus.S_AXI_WVALID = 1'b0;
    timeout("w_handshake");
  endtask

  task automatic send_ar(input logic [3:0] a);
    bus.S_AXI_ARADDR = a;
    bus.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.S_AXI_ARREADY) begin
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        return;
      end
    end
    bus.S_AXI_ARVALID = 1'b0;
    timeout("ar_handshake");
  endtask

  task automatic get_b(output logic [3:0] pulse);
    pulse = '0;
    bus.S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.S_AXI_BVALID) begin
        pulse = reg_wr_pulse;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        return;
      end
    end
    bus.S_AXI_BREADY = 1'b0;
    timeout("b_handshake");
  endtask

  task automatic get_r(output logic [31:0] d);
    d = '0;
    bus.S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.S_AXI_RVALID) begin
        d = bus.S_AXI_RDATA;
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b0;
        return;
      end
    end
    bus.S_AXI_RREADY = 1'b0;
    timeout("r_handshake");
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [3:0] pulse);
    fork
      send_aw(a);
      send_w(d, s);
    join
    get_b(pulse);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    send_ar(a);
    get_r(d);
  endtask

  // ---------------- directed scenarios ----------------
  logic [3:0]  p;
  logic [31:0] d;

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset and first edge after release
    repeat (3) @(negedge clk);
    check("rst_awready", bus.S_AXI_AWREADY, 1'b0);
    check("rst_arready", bus.S_AXI_ARREADY, 1'b0);
    check("rst_reg_q", reg_q, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("pre_edge_awready", bus.S_AXI_AWREADY, 1'b0);
    check("pre_edge_wready", bus.S_AXI_WREADY, 1'b0);
    @(negedge clk);
    check("post_edge_awready", bus.S_AXI_AWREADY, 1'b1);
    check("post_edge_wready", bus.S_AXI_WREADY, 1'b1);
    check("post_edge_arready", bus.S_AXI_ARREADY, 1'b1);
    @(posedge clk); #1;

    // Basic write/read of all four registers
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(4 * i), 32'(i + 1), 4'hF, p);
      check("basic_pulse", p, 4'b0001 << i);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), d);
      check("basic_read", d, 32'(i + 1));
    end

    // W three cycles ahead of AW
    send_w(32'hDEADBEEF, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("ooo_wready_low", bus.S_AXI_WREADY, 1'b0);
      check("ooo_bvalid_low", bus.S_AXI_BVALID, 1'b0);
    end
    @(posedge clk); #1;
    send_aw(4'h8);
    @(negedge clk);
    check("ooo_bvalid", bus.S_AXI_BVALID, 1'b1);
    @(posedge clk); #1;
    get_b(p);
    axi_read(4'h8, d);
    check("ooo_read", d, 32'hDEADBEEF);

    // Write-response backpressure
    fork
      send_aw(4'hC);
      send_w(32'h00000055, 4'hF);
    join
    repeat (5) begin
      @(negedge clk);
      check("bp_bvalid", bus.S_AXI_BVALID, 1'b1);
      check("bp_awready", bus.S_AXI_AWREADY, 1'b0);
      check("bp_wready", bus.S_AXI_WREADY, 1'b0);
    end
    @(posedge clk); #1;
    get_b(p);

    // Read-data backpressure
    send_ar(4'hC);
    repeat (5) begin
      @(negedge clk);
      check("bp_rvalid", bus.S_AXI_RVALID, 1'b1);
      check("bp_rdata", bus.S_AXI_RDATA, 32'h00000055);
      check("bp_arready", bus.S_AXI_ARREADY, 1'b0);
    end
    @(posedge clk); #1;
    get_r(d);
    check("bp_read", d, 32'h00000055);

    // Read and commit to the same register on the same edge
    axi_write(4'h4, 32'h11, 4'hF, p);
    fork
      send_aw(4'h4);
      send_w(32'h22, 4'hF);
      send_ar(4'h4);
    join
    get_b(p);
    get_r(d);
    check("collide_old", d, 32'h11);
    axi_read(4'h4, d);
    check("collide_new", d, 32'h22);
    axi_read(4'h7, d);
    check("alias_read", d, 32'h22);

    // Byte strobes
    axi_write(4'hC, 32'hAABBCCDD, 4'hF, p);
    axi_write(4'hC, 32'h11223344, 4'b0101, p);
    check("strb_pulse", p, 4'b1000);
    axi_read(4'hC, d);
`ifdef MYFIRAXI_WSTRB_EN
    check("strb_read", d, 32'hAA22CC44);
`else
    check("strb_read", d, 32'h11223344);
`endif

    // Reset while a response is owed
    fork
      send_aw(4'h0);
      send_w(32'h77, 4'hF);
    join
    @(negedge clk);
    check("mid_bvalid_before", bus.S_AXI_BVALID, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_bvalid_dropped", bus.S_AXI_BVALID, 1'b0);
    check("mid_reg_q", reg_q, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), d);
      check("post_rst_read", d, 32'h0);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/myfiraxi_axil_slave.md
# myfiraxi_axil_slave

AXI4-Lite responder holding the four 32-bit memory-mapped registers of the myfiraxi FIR peripheral. The block sits between the AXI interconnect (driven in simulation by the AXI VIP master agent) and the FIR datapath. It accepts single-beat writes and reads, exposes the register contents to the datapath, and emits a one-cycle commit pulse per register write.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers at 0x0, 0x4, 0x8, 0xC
- S_AXI_ACLK  in  1  single clock; all logic on rising edge
- S_AXI_ARESETN  in  1  asynchronous, active-low reset
- S_AXI_AWADDR  in  4  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  always 2'b00 (OKAY)
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  4  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always 2'b00
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- reg_q  out  128  register contents; reg n occupies bits [32n+31:32n]
- reg_wr_pulse  out  4  one-hot, one cycle, bit n set when reg n is committed

## Operation
- Register index is addr[3:2]. addr[1:0] is ignored, and every address decodes, so no error responses exist.
- The write FSM has states W_IDLE, W_GOT_ADDR, W_GOT_DATA, and W_RESP.
  - AW and W are accepted independently and in either order. Each accepted beat is latched.
  - W_IDLE moves to W_GOT_ADDR on AW only, to W_GOT_DATA on W only, and to W_RESP on both in the same cycle.
  - W_GOT_ADDR and W_GOT_DATA move to W_RESP when the missing beat arrives.
  - W_RESP returns to W_IDLE on BVALID&&BREADY.
- Commit happens on entry to W_RESP. On that edge the register is written, the reg_wr_pulse bit is set for one cycle, and BVALID rises.
- AWREADY is high only in W_IDLE and W_GOT_DATA. WREADY is high only in W_IDLE and W_GOT_ADDR. Both are low in W_RESP, so at most one write is outstanding.
- The read FSM has states R_IDLE and R_DATA.
  - ARREADY equals (state==R_IDLE).
  - On AR handshake, RDATA is latched from the register array and the FSM enters R_DATA with RVALID=1.
  - RDATA and RVALID are held until RREADY, then the FSM returns to R_IDLE.
- Read and write paths are fully independent. If a read latches the same register on the same edge as a write commit, it returns the pre-write value.
- All outputs reset to 0, including every register, both FSMs (to IDLE), and the pulses. Reset is asynchronous and may be asserted mid-transaction; any pending B or R is dropped without completion.

## Timing
- Write latency: BVALID is visible the cycle after the last of the AW/W handshakes. reg_q reflects the new value in that same cycle.
- Read latency: RVALID is visible the cycle after the AR handshake.
- Best-case throughput: one write every 2 cycles and one read every 2 cycles, running concurrently.
- Output stability: BVALID, RVALID, and RDATA are stable under backpressure.
- READY dependence: no READY depends combinationally on the matching VALID.

## Configuration
- MYFIRAXI_WSTRB_EN defined: only byte lanes with WSTRB[k]=1 are updated; other lanes keep their old value. A write with WSTRB=0 still completes with OKAY, pulses reg_wr_pulse, and leaves data unchanged.
- Undefined: WSTRB is ignored and the full 32-bit word is written.

## Test plan
- Reset and basic write/read:
  - During reset and after release, all READY/VALID outputs and reg_q are 0; AWREADY, WREADY, and ARREADY go to 1 at the first edge after deassertion.
  - Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read back all four: each returns the written value with RRESP=OKAY, and reg_wr_pulse goes 0001, 0010, 0100, 1000 in order.
- Out-of-order beats: W=0xDEADBEEF arrives 3 cycles before AW=0x8. WREADY stays low after W is accepted, and BVALID rises the cycle after the AW handshake. Register 2 reads 0xDEADBEEF.
- Backpressure: hold BREADY=0 for 5 cycles. BVALID stays 1 and AWREADY/WREADY stay 0 throughout. Hold RREADY=0 for 5 cycles: RDATA is stable and ARREADY=0.
- Same-cycle collision: register 1 holds 0x11. A read of 0x4 handshakes on the same edge as the commit of 0x22 to 0x4; the read returns 0x11 and a following read returns 0x22.
- Strobes:
  - With MYFIRAXI_WSTRB_EN: register 3 holds 0xAABBCCDD; write 0x11223344 with WSTRB=4'b0101, and register 3 reads 0xAA22CC44.
  - Without the macro: the same write yields 0x11223344.
- Reset mid-transaction: assert ARESETN=0 while BVALID=1. BVALID drops immediately and all registers read 0 after release.
